switch_allocator_rr: RTL

//  Separable input-first switch allocator for the NoC router. Each cycle it picks at most one VC per

---
 rtl/switch_allocator_rr_pkg.sv | 25 ++
 rtl/switch_allocator_rr_arb.sv | 46 ++++
 rtl/switch_allocator_rr.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/switch_allocator_rr_pkg.sv
// Shared router parameters and types for the switch allocator.
// Consumers import this package with: import noc_params::*;
package noc_params;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_W   = 3;

  typedef enum logic [PORT_W-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  // One input VC's view of the allocation request.
  typedef struct packed {
    logic               req;
    port_t              out_port;
    logic [VC_SIZE-1:0] downstream_vc;
  } sa_req_t;

endpackage

// File: rtl/switch_allocator_rr_arb.sv
// Round-robin arbiter with a registered priority pointer.
// The search starts at r_ptr. On i_upd with a grant present, the pointer
// moves to one past the winner, so the winner has lowest priority next time.
module round_robin_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_upd,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_any;
  int            w_k;

  // Rotating priority search, starting at the pointer.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_any = 1'b0;
    w_k   = 0;
    for (int i = 0; i < N; i++) begin
      w_k = int'(r_ptr) + i;
      if (w_k >= N) w_k = w_k - N;
      if (!w_any && i_req[w_k]) begin
        w_any      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = IW'(w_k);
      end
    end
  end

  // The pointer advances past the winner only when the grant is actually used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_upd && w_any) begin
      r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/switch_allocator_rr.sv
// Separable input-first switch allocator with round-robin arbitration at both stages.
// Stage 1 picks one eligible VC per input port.
// Stage 2 picks one input per output port among the stage-1 candidates.
// Optional feature macro: SA_GRANT_COUNT_EN adds saturating per-output grant counters.
module switch_allocator_rr
  import noc_params::*;
#(
  parameter int PORT_NUM  = noc_params::PORT_NUM,
  parameter int VC_NUM    = noc_params::VC_NUM,
  parameter int CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]  req_i,
  input  port_t                            out_port_i      [PORT_NUM][VC_NUM],
  input  logic [VC_SIZE-1:0]               downstream_vc_i [PORT_NUM][VC_NUM],
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]  on_off_i,
  output logic [PORT_NUM-1:0]              valid_sel_o,
  output logic [VC_SIZE-1:0]               vc_sel_o        [PORT_NUM],
  output logic [PORT_NUM-1:0]              xbar_valid_o,
  output port_t                            xbar_sel_o      [PORT_NUM]
`ifdef SA_GRANT_COUNT_EN
  , output logic [CNT_WIDTH-1:0]           grant_cnt_o     [PORT_NUM]
`endif
);

  sa_req_t             w_req     [PORT_NUM][VC_NUM];
  logic [VC_NUM-1:0]   w_elig    [PORT_NUM];
  logic [VC_NUM-1:0]   w_s1_gnt  [PORT_NUM];
  logic [VC_SIZE-1:0]  w_s1_idx  [PORT_NUM];
  logic [PORT_NUM-1:0] w_s1_any;
  port_t               w_s1_port [PORT_NUM];
  logic [PORT_NUM-1:0] w_s2_req  [PORT_NUM];
  logic [PORT_NUM-1:0] w_s2_gnt  [PORT_NUM];
  logic [PORT_W-1:0]   w_s2_idx  [PORT_NUM];
  logic [PORT_NUM-1:0] w_s2_any;
  logic [PORT_NUM-1:0] w_in_win;

  // Eligibility: a valid request aimed at a real port whose downstream VC is switched on.
  // An out-of-range port code never indexes on_off_i.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      w_elig[p] = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        w_req[p][v] = '{req:           req_i[p][v],
                        out_port:      out_port_i[p][v],
                        downstream_vc: downstream_vc_i[p][v]};
        if (w_req[p][v].req && (int'(w_req[p][v].out_port) < PORT_NUM)) begin
          w_elig[p][v] = on_off_i[w_req[p][v].out_port][w_req[p][v].downstream_vc];
        end
      end
    end
  end

  // Stage 1: per-input VC arbiters. The pointer moves only if the input wins stage 2,
  // so a stage-2 loser retries the same VC first next cycle.
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_in
    round_robin_arbiter #(.N(VC_NUM), .IW(VC_SIZE)) u_vc_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_elig[p]),
      .i_upd (w_in_win[p]),
      .o_gnt (w_s1_gnt[p]),
      .o_idx (w_s1_idx[p])
    );
    assign w_s1_any[p]  = |w_s1_gnt[p];
    assign w_s1_port[p] = out_port_i[p][w_s1_idx[p]];
  end

  // Route each stage-1 candidate to the request vector of its target output.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      w_s2_req[o] = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        w_s2_req[o][p] = w_s1_any[p] && (int'(w_s1_port[p]) == o);
      end
    end
  end

  // Stage 2: per-output input arbiters.
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    round_robin_arbiter #(.N(PORT_NUM), .IW(PORT_W)) u_port_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_s2_req[o]),
      .i_upd (w_s2_any[o]),
      .o_gnt (w_s2_gnt[o]),
      .o_idx (w_s2_idx[o])
    );
    assign w_s2_any[o] = |w_s2_gnt[o];
  end

  // An input has won if any output granted it.
  always_comb begin
    w_in_win = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_s2_gnt[o][p]) w_in_win[p] = 1'b1;
      end
    end
  end

  // Drive the grant outputs. Idle outputs are 0, and everything is masked while in reset.
  always_comb begin
    valid_sel_o  = '0;
    xbar_valid_o = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      vc_sel_o[p]   = '0;
      xbar_sel_o[p] = LOCAL;
    end
    if (!rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_in_win[p]) begin
          valid_sel_o[p] = 1'b1;
          vc_sel_o[p]    = w_s1_idx[p];
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (w_s2_any[o]) begin
          xbar_valid_o[o] = 1'b1;
          xbar_sel_o[o]   = port_t'(w_s2_idx[o]);
        end
      end
    end
  end

`ifdef SA_GRANT_COUNT_EN
  logic [CNT_WIDTH-1:0] r_grant_cnt [PORT_NUM];

  // Saturating per-output grant counters.
  always_ff @(posedge clk) begin
    for (int o = 0; o < PORT_NUM; o++) begin
      if (rst) begin
        r_grant_cnt[o] <= '0;
      end else if (xbar_valid_o[o] && (r_grant_cnt[o] != '1)) begin
        r_grant_cnt[o] <= r_grant_cnt[o] + 1'b1;
      end
    end
  end

  assign grant_cnt_o = r_grant_cnt;
`endif

endmodule
